// File: rtl/autoconfig_master_pkg.sv
// Shared constants, state encoding and size decode for the Zorro II AutoConfig initiator.
package autoconfig_master_pkg;

  // Register offsets within the config page, as seen on ADDR[8:1]
  localparam logic [7:0] RegType   = 8'h00;
  localparam logic [7:0] RegSize   = 8'h01;
  localparam logic [7:0] RegBaseHi = 8'h24;
  localparam logic [7:0] RegBaseLo = 8'h25;
  localparam logic [7:0] RegShut   = 8'h26;

  // Config page and allocation pools, in 64 KB units (ADDR[23:16])
  localparam logic [7:0] CfgPage  = 8'hE8;
  localparam logic [7:0] MemBase  = 8'h20;
  localparam logic [8:0] MemLimit = 9'h0A0;
  localparam logic [7:0] IoBase   = 8'hE9;
  localparam logic [8:0] IoLimit  = 9'h0F0;

  typedef enum logic [2:0] {
    StIdle,
    StRdType,
    StRdSize,
    StAlloc,
    StWrLo,
    StWrHi,
    StWrShut
  } scan_state_e;

  // Size code to 64 KB units; code 0 is the 8 MB board
  function automatic logic [8:0] size_units(input logic [2:0] code);
    logic [8:0] units;
    unique case (code)
      3'd0:    units = 9'd128;
      3'd1:    units = 9'd1;
      3'd2:    units = 9'd2;
      3'd3:    units = 9'd4;
      3'd4:    units = 9'd8;
      3'd5:    units = 9'd16;
      3'd6:    units = 9'd32;
      default: units = 9'd64;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/autoconfig_master_bus_cycle.sv
// z2_bus_cycle: one SETUP/STROBE/RELEASE nibble bus cycle with DTACK timeout.
// A request seen in idle or in RELEASE launches the next cycle back-to-back.
module z2_bus_cycle #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        req,
  input  logic        rw,
  input  logic [22:0] addr,
  input  logic [3:0]  wdata,
  output logic        ack,
  output logic [3:0]  rdata,
  output logic        timeout,
  output logic [22:0] ADDR,
  output logic        AS_n,
  output logic        RW,
  output logic [3:0]  DOUT,
  input  logic [3:0]  DIN,
  input  logic        DTACK_n
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {PhIdle, PhSetup, PhStrobe, PhRelease} phase_e;

  phase_e          phase_q, phase_d;
  logic [CntW-1:0] cnt_q;
  logic            to_q;
  logic [3:0]      rdata_q;
  logic [22:0]     addr_q;
  logic            rw_q;
  logic [3:0]      dout_q;
  logic            launch, dtack_seen, expired;

  assign launch     = req && (phase_q == PhIdle || phase_q == PhRelease);
  assign dtack_seen = (phase_q == PhStrobe) && !DTACK_n;
  assign expired    = (phase_q == PhStrobe) && DTACK_n && (cnt_q == CntMax);

  // Phase sequencing
  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      PhIdle:    if (req) phase_d = PhSetup;
      PhSetup:   phase_d = PhStrobe;
      PhStrobe:  if (dtack_seen || expired) phase_d = PhRelease;
      PhRelease: phase_d = req ? PhSetup : PhIdle;
      default:   phase_d = PhIdle;
    endcase
  end

  // Phase, strobe counter, captured read data and held bus fields
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      phase_q <= PhIdle;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      dout_q  <= '0;
    end else begin
      phase_q <= phase_d;
      if (launch) begin
        addr_q <= addr;
        rw_q   <= rw;
        dout_q <= wdata;
      end
      if (phase_q == PhSetup) cnt_q <= '0;
      else if (phase_q == PhStrobe) cnt_q <= cnt_q + CntW'(1);
      if (dtack_seen) begin
        rdata_q <= DIN;
        to_q    <= 1'b0;
      end else if (expired) begin
        to_q <= 1'b1;
      end
    end
  end

  // AS_n decodes straight from the phase so reset releases it asynchronously
  assign AS_n    = (phase_q != PhStrobe);
  assign ADDR    = addr_q;
  assign RW      = rw_q;
  assign DOUT    = dout_q;
  assign rdata   = rdata_q;
  assign ack     = (phase_q == PhRelease) && !to_q;
  assign timeout = (phase_q == PhRelease) && to_q;

endmodule

// File: rtl/autoconfig_master.sv
// Zorro II AutoConfig initiator: scans the $E8 page, allocates 64 KB-aligned bases
// from the memory or I/O pool and commits each board, or shuts it up if it does not fit.
module autoconfig_master
  import autoconfig_master_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned MAX_BOARDS = 7
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        start,
  output logic [22:0] ADDR,
  output logic        AS_n,
  output logic        RW,
  output logic [3:0]  DOUT,
  input  logic [3:0]  DIN,
  input  logic        DTACK_n,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  boards,
  output logic [7:0]  mem_ptr,
  output logic [7:0]  io_ptr
);

  scan_state_e state_q, state_d;
  logic        is_mem_q, is_mem_d;
  logic [2:0]  size_q, size_d;
  logic [7:0]  base_q, base_d;
  logic [7:0]  mem_ptr_q, mem_ptr_d, io_ptr_q, io_ptr_d;
  logic [2:0]  boards_q, boards_d;
  logic        error_q, error_d, done_q, done_d;

  logic        bus_req, bus_rw, bus_ack, bus_to;
  logic [7:0]  bus_off;
  logic [3:0]  bus_wdata, bus_rdata;

  logic [8:0]  units, ptr9, limit, align_base, alloc_base, alloc_end;
  logic        fits;
  logic        unused_bits;

  assign unused_bits = ^{bus_rdata[3], alloc_base[8], alloc_end[8]};

  // Allocator: align the pool pointer up to the board size and test against the pool end
  always_comb begin
    units      = size_units(size_q);
    ptr9       = is_mem_q ? {1'b0, mem_ptr_q} : {1'b0, io_ptr_q};
    limit      = is_mem_q ? MemLimit : IoLimit;
    align_base = (ptr9 + units - 9'd1) & ~(units - 9'd1);
    if (is_mem_q && size_q == 3'd0) begin
      // 8 MB board only fits when the whole memory pool is still free
      alloc_base = {1'b0, MemBase};
      fits       = (mem_ptr_q == MemBase);
    end else begin
      alloc_base = align_base;
      fits       = (align_base + units) <= limit;
    end
    alloc_end = alloc_base + units;
  end

  // Scan FSM next state and datapath updates
  always_comb begin
    state_d   = state_q;
    is_mem_d  = is_mem_q;
    size_d    = size_q;
    base_d    = base_q;
    mem_ptr_d = mem_ptr_q;
    io_ptr_d  = io_ptr_q;
    boards_d  = boards_q;
    error_d   = error_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !done_q) begin
          state_d   = StRdType;
          error_d   = 1'b0;
          boards_d  = '0;
          mem_ptr_d = MemBase;
          io_ptr_d  = IoBase;
        end
      end
      StRdType: begin
        if (bus_ack) begin
          is_mem_d = bus_rdata[1];
          state_d  = StRdSize;
        end else if (bus_to) begin
          // Nobody answered: end of chain, not an error
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StRdSize: begin
        if (bus_ack) begin
          size_d  = bus_rdata[2:0];
          state_d = StAlloc;
        end else if (bus_to) begin
          error_d = 1'b1;
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StAlloc: begin
        if (fits) begin
          base_d   = alloc_base[7:0];
          boards_d = boards_q + 3'd1;
          if (is_mem_q) mem_ptr_d = alloc_end[7:0];
          else          io_ptr_d  = alloc_end[7:0];
          state_d = StWrLo;
        end else begin
          state_d = StWrShut;
        end
      end
      StWrLo, StWrHi, StWrShut: begin
        if (bus_to) begin
          error_d = 1'b1;
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (bus_ack) begin
          if (state_q == StWrLo) begin
            state_d = StWrHi;
          end else if (state_q == StWrHi && boards_q == 3'(MAX_BOARDS)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StRdType;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus request decoded from the next state so consecutive cycles run back-to-back
  always_comb begin
    bus_req   = 1'b1;
    bus_rw    = 1'b1;
    bus_wdata = '0;
    bus_off   = RegType;
    unique case (state_d)
      StRdType: bus_off = RegType;
      StRdSize: bus_off = RegSize;
      StWrLo: begin
        bus_rw    = 1'b0;
        bus_off   = RegBaseLo;
        bus_wdata = alloc_base[3:0];  // only entered from ALLOC, where alloc_base is live
      end
      StWrHi: begin
        bus_rw    = 1'b0;
        bus_off   = RegBaseHi;
        bus_wdata = base_q[7:4];
      end
      StWrShut: begin
        bus_rw  = 1'b0;
        bus_off = RegShut;
      end
      default: bus_req = 1'b0;
    endcase
  end

  // Scan state and result registers
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= StIdle;
      is_mem_q  <= 1'b0;
      size_q    <= '0;
      base_q    <= '0;
      mem_ptr_q <= MemBase;
      io_ptr_q  <= IoBase;
      boards_q  <= '0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_mem_q  <= is_mem_d;
      size_q    <= size_d;
      base_q    <= base_d;
      mem_ptr_q <= mem_ptr_d;
      io_ptr_q  <= io_ptr_d;
      boards_q  <= boards_d;
      error_q   <= error_d;
      done_q    <= done_d;
    end
  end

  z2_bus_cycle #(
    .TIMEOUT (TIMEOUT)
  ) u_bus (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .req     (bus_req),
    .rw      (bus_rw),
    .addr    ({CfgPage, 7'd0, bus_off}),
    .wdata   (bus_wdata),
    .ack     (bus_ack),
    .rdata   (bus_rdata),
    .timeout (bus_to),
    .ADDR    (ADDR),
    .AS_n    (AS_n),
    .RW      (RW),
    .DOUT    (DOUT),
    .DIN     (DIN),
    .DTACK_n (DTACK_n)
  );

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign error   = error_q;
  assign boards  = boards_q;
  assign mem_ptr = mem_ptr_q;
  assign io_ptr  = io_ptr_q;

endmodule
